// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy obstacle generator blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package flappy_pkg;

    // Column generator states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PIPE  = 2'd1,
        SPACE = 2'd2
    } pipe_state_t;

    // Fibonacci feedback taps 16,14,13,11 (bit 15 = tap 16).
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; shifts left one bit per advance, feedback enters at bit 0.
// Latency: new value visible one cycle after advance is sampled.
// Backpressure: none; value holds while advance is low.
//
// Ports: Clock, Reset (async active-low, loads seed), advance, seed, value.
module lfsr16
    import flappy_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] r_value;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_value <= seed;
        end else if (advance) begin
            r_value <= {r_value[14:0], ^(r_value & LFSR_TAPS)};
        end
    end

    assign value = r_value;

endmodule

// File: rtl/pipe_column_gen.sv
// Flappy Bird obstacle column generator: pipe columns with a random, step-limited gap, blank spacers between.
// Latency: the column for a step is registered at the same posedge that samples step.
// Backpressure: none; outputs hold between steps, enable low forces idle and drops any step.
//
// Ports: Clock, Reset (async active-low), enable, step -> col (1 = lit wall, MSB = top),
//        pipe, pipe_start (one-cycle pulse on first column of a pipe), gap_pos (lowest gap row).
module pipe_column_gen
    import flappy_pkg::*;
#(
    parameter int          ROWS     = 8,
    parameter int          GAP      = 2,
    parameter int          MIN_EDGE = 1,
    parameter int          PIPE_W   = 1,
    parameter int          SPACING  = 3,
    parameter int          MAX_STEP = 2,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    enable,
    input  logic                    step,
    output logic [ROWS-1:0]         col,
    output logic                    pipe,
    output logic                    pipe_start,
    output logic [$clog2(ROWS)-1:0] gap_pos
);

    localparam int GPW  = $clog2(ROWS);
    localparam int NPOS = ROWS - GAP - 2*MIN_EDGE + 1;
    localparam logic [15:0]    EFF_SEED  = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
    localparam logic [GPW-1:0] RESET_GAP = GPW'((ROWS - GAP) / 2);

    if (NPOS < 1) begin : g_bad_npos
        $error("pipe_column_gen: no legal gap position for ROWS/GAP/MIN_EDGE");
    end
    if (PIPE_W < 1) begin : g_bad_pipe_w
        $error("pipe_column_gen: PIPE_W must be at least 1");
    end
    if (MAX_STEP < 1) begin : g_bad_max_step
        $error("pipe_column_gen: MAX_STEP must be at least 1");
    end

    // Random candidate in the legal range, then pulled to within MAX_STEP of
    // the previous gap. Both ends of the window intersect the legal range
    // because prev is itself legal, so the result stays legal.
    function automatic logic [GPW-1:0] next_gap(input logic [15:0] lfsr,
                                                input logic [GPW-1:0] prev);
        int cand;
        int p;
        cand = MIN_EDGE + int'(lfsr % 16'(NPOS));
        p    = int'(prev);
        if (cand > p + MAX_STEP) begin
            cand = p + MAX_STEP;
        end else if (cand < p - MAX_STEP) begin
            cand = p - MAX_STEP;
        end
        return GPW'(cand);
    endfunction

    function automatic logic [ROWS-1:0] pipe_col(input logic [GPW-1:0] g);
        logic [ROWS-1:0] c;
        for (int i = 0; i < ROWS; i++) begin
            c[i] = !((i >= int'(g)) && (i < int'(g) + GAP));
        end
        return c;
    endfunction

    pipe_state_t      r_state;
    logic [15:0]      r_cnt;
    logic [15:0]      r_space;
    logic [ROWS-1:0]  r_col;
    logic             r_pipe;
    logic             r_start;
    logic [GPW-1:0]   r_gap;

    logic             w_accept;
    logic             w_start_pipe;
    logic [15:0]      w_lfsr;
    logic [GPW-1:0]   w_new_gap;
    logic [ROWS-1:0]  w_new_col;

    assign w_accept  = enable & step;
    assign w_new_gap = next_gap(w_lfsr, r_gap);
    assign w_new_col = pipe_col(w_new_gap);

    lfsr16 u_lfsr (
        .Clock   (Clock),
        .Reset   (Reset),
        .advance (w_accept),
        .seed    (EFF_SEED),
        .value   (w_lfsr)
    );

    // A new pipe begins from idle, after the last blank, or straight after
    // the last pipe column when there is no spacing.
    always_comb begin
        w_start_pipe = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE:    w_start_pipe = 1'b1;
                PIPE:    w_start_pipe = (r_cnt >= 16'(PIPE_W)) && (SPACING == 0);
                SPACE:   w_start_pipe = (r_space >= 16'(SPACING));
                default: w_start_pipe = 1'b1;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_space <= '0;
            r_col   <= '0;
            r_pipe  <= 1'b0;
            r_start <= 1'b0;
            r_gap   <= RESET_GAP;
        end else if (!enable) begin
            // Gap and LFSR are held so play resumes from the same course.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_space <= '0;
            r_col   <= '0;
            r_pipe  <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (w_start_pipe) begin
                r_state <= PIPE;
                r_gap   <= w_new_gap;
                r_col   <= w_new_col;
                r_pipe  <= 1'b1;
                r_start <= 1'b1;
                r_cnt   <= 16'd1;
                r_space <= '0;
            end else if (w_accept) begin
                if (r_state == PIPE) begin
                    if (r_cnt < 16'(PIPE_W)) begin
                        r_cnt <= r_cnt + 16'd1;
                    end else begin
                        r_state <= SPACE;
                        r_col   <= '0;
                        r_pipe  <= 1'b0;
                        r_space <= 16'd1;
                    end
                end else begin
                    r_col   <= '0;
                    r_pipe  <= 1'b0;
                    r_space <= r_space + 16'd1;
                end
            end
        end
    end

    assign col        = r_col;
    assign pipe       = r_pipe;
    assign pipe_start = r_start;
    assign gap_pos    = r_gap;

endmodule

// File: tb/tb_pipe_column_gen.sv
// Bench for pipe_column_gen: default instance (a) and a PIPE_W=2/SPACING=0 instance (b).
// Expected columns come from a reference sequence model pushed to a scoreboard per step.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_pipe_column_gen;

    typedef struct packed {
        logic [7:0] col;
        logic       pipe;
        logic       start;
        logic [2:0] gap;
    } exp_t;

    typedef struct packed {
        logic [15:0] lfsr;
        logic [2:0]  gap;
        int          k;      // column index within the pipe+space period, -1 = fresh
    } mdl_t;

    localparam logic [15:0] SEED0 = 16'hACE1;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       en_a = 1'b0, step_a = 1'b0;
    logic       en_b = 1'b0, step_b = 1'b0;
    logic [7:0] col_a, col_b;
    logic       pipe_a, pipe_b, start_a, start_b;
    logic [2:0] gap_a, gap_b;

    int   checks   = 0;
    int   failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t last_a;
    mdl_t m_a, m_b;

    always #5 Clock = ~Clock;

    pipe_column_gen u_a (
        .Clock(Clock), .Reset(Reset), .enable(en_a), .step(step_a),
        .col(col_a), .pipe(pipe_a), .pipe_start(start_a), .gap_pos(gap_a)
    );

    pipe_column_gen #(.PIPE_W(2), .SPACING(0)) u_b (
        .Clock(Clock), .Reset(Reset), .enable(en_b), .step(step_b),
        .col(col_b), .pipe(pipe_b), .pipe_start(start_b), .gap_pos(gap_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Defaults: legal gaps 1..5 (5 positions), max move 2.
    function automatic logic [2:0] pick_gap(input logic [15:0] l, input logic [2:0] prev);
        int c;
        int p;
        c = 1 + int'(l % 16'd5);
        p = int'(prev);
        if (c > p + 2) c = p + 2;
        if (c < p - 2) c = p - 2;
        return 3'(c);
    endfunction

    function automatic logic [7:0] wall_col(input logic [2:0] g);
        logic [7:0] m;
        m = 8'hFF;
        m[int'(g)]     = 1'b0;
        m[int'(g) + 1] = 1'b0;
        return m;
    endfunction

    function automatic void model_step(input int pw, input int sp, input mdl_t mi,
                                       output mdl_t mo, output exp_t e);
        mo = mi;
        e  = '0;
        if (mi.k < 0 || mi.k >= pw + sp - 1) begin
            mo.gap = pick_gap(mi.lfsr, mi.gap);
            mo.k   = 0;
        end else begin
            mo.k = mi.k + 1;
        end
        e.gap = mo.gap;
        if (mo.k < pw) begin
            e.col   = wall_col(mo.gap);
            e.pipe  = 1'b1;
            e.start = (mo.k == 0);
        end
        mo.lfsr = lfsr_next(mi.lfsr);
    endfunction

    task automatic cmp(input string tag, input exp_t e, input logic [7:0] c,
                       input logic p, input logic s, input logic [2:0] g);
        chk({tag, ".col"},   32'(c), 32'(e.col));
        chk({tag, ".pipe"},  32'(p), 32'(e.pipe));
        chk({tag, ".start"}, 32'(s), 32'(e.start));
        chk({tag, ".gap"},   32'(g), 32'(e.gap));
    endtask

    task automatic step_a_once(input string tag);
        exp_t e, got;
        mdl_t mn;
        @(negedge Clock);
        step_a = 1'b1;
        model_step(1, 3, m_a, mn, e);
        m_a = mn;
        q_a.push_back(e);
        @(posedge Clock);
        #1;
        step_a = 1'b0;
        got = q_a.pop_front();
        cmp(tag, got, col_a, pipe_a, start_a, gap_a);
        last_a = got;
    endtask

    task automatic step_b_once(input string tag);
        exp_t e, got;
        mdl_t mn;
        @(negedge Clock);
        step_b = 1'b1;
        model_step(2, 0, m_b, mn, e);
        m_b = mn;
        q_b.push_back(e);
        @(posedge Clock);
        #1;
        step_b = 1'b0;
        got = q_b.pop_front();
        cmp(tag, got, col_b, pipe_b, start_b, gap_b);
    endtask

    // Cycle without a step: column and gap hold, pipe_start drops.
    task automatic idle_a(input string tag);
        exp_t e;
        @(negedge Clock);
        step_a = 1'b0;
        @(posedge Clock);
        #1;
        e       = last_a;
        e.start = 1'b0;
        cmp(tag, e, col_a, pipe_a, start_a, gap_a);
        last_a = e;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] first_gap;
        logic [2:0] prev_obs;
        logic [7:0] seen;
        int         zeros;
        int         d;

        // Reset held two cycles with steps requested: nothing changes.
        en_a   = 1'b1;
        step_a = 1'b1;
        repeat (2) begin
            @(posedge Clock);
            #1;
            chk("rst.col",   32'(col_a),   32'h00);
            chk("rst.pipe",  32'(pipe_a),  32'h0);
            chk("rst.start", 32'(start_a), 32'h0);
            chk("rst.gap",   32'(gap_a),   32'd3);
        end
        @(negedge Clock);
        step_a = 1'b0;
        Reset  = 1'b1;
        m_a    = '{lfsr: SEED0, gap: 3'd3, k: -1};
        m_b    = '{lfsr: SEED0, gap: 3'd3, k: -1};
        last_a = '{col: 8'h00, pipe: 1'b0, start: 1'b0, gap: 3'd3};
        idle_a("post_rst_idle");

        // Eight back-to-back steps: pipe, blank x3, pipe, blank x3.
        step_a_once("seq1");
        first_gap = m_a.gap;
        for (int i = 2; i <= 8; i++) step_a_once($sformatf("seq%0d", i));
        idle_a("hold1");
        idle_a("hold2");

        // 1000 pipes with random step spacing plus course properties.
        seen     = '0;
        prev_obs = m_a.gap;
        for (int p = 0; p < 1000; p++) begin
            for (int c = 0; c < 4; c++) begin
                repeat ($urandom_range(0, 2)) idle_a("rnd_idle");
                step_a_once("rnd");
                if (c == 0) begin
                    zeros = 0;
                    for (int b = 0; b < 8; b++) if (!col_a[b]) zeros++;
                    chk("prop.zeros", 32'(zeros), 32'd2);
                    chk("prop.gap_lo_zero", 32'(col_a[gap_a]), 32'h0);
                    chk("prop.gap_hi_zero", 32'(col_a[(int'(gap_a) + 1) % 8]), 32'h0);
                    chk("prop.gap_legal", 32'(gap_a >= 3'd1 && gap_a <= 3'd5), 32'h1);
                    d = int'(gap_a) - int'(prev_obs);
                    chk("prop.delta", 32'(d <= 2 && d >= -2), 32'h1);
                    prev_obs = gap_a;
                    seen[gap_a] = 1'b1;
                end
            end
        end
        chk("prop.all_positions", 32'(seen[5:1]), 32'h1F);

        // Drop enable during the second blank, with a step in the same cycle.
        step_a_once("drop.pipe");
        step_a_once("drop.blank1");
        step_a_once("drop.blank2");
        @(negedge Clock);
        en_a   = 1'b0;
        step_a = 1'b1;
        @(posedge Clock);
        #1;
        step_a = 1'b0;
        m_a.k  = -1;
        last_a = '{col: 8'h00, pipe: 1'b0, start: 1'b0, gap: m_a.gap};
        cmp("drop.edge", last_a, col_a, pipe_a, start_a, gap_a);
        @(negedge Clock);
        en_a = 1'b1;
        idle_a("drop.reenable");
        step_a_once("drop.restart");

        // Async reset pulse between edges while showing a pipe column.
        @(negedge Clock);
        #1 Reset = 1'b0;
        #1;
        chk("arst.col",   32'(col_a),   32'h00);
        chk("arst.pipe",  32'(pipe_a),  32'h0);
        chk("arst.start", 32'(start_a), 32'h0);
        chk("arst.gap",   32'(gap_a),   32'd3);
        #1 Reset = 1'b1;
        m_a    = '{lfsr: SEED0, gap: 3'd3, k: -1};
        m_b    = '{lfsr: SEED0, gap: 3'd3, k: -1};
        last_a = '{col: 8'h00, pipe: 1'b0, start: 1'b0, gap: 3'd3};
        step_a_once("arst.first");
        chk("arst.same_gap", 32'(gap_a), 32'(first_gap));

        // PIPE_W=2, SPACING=0: paired pipe columns, no blanks.
        @(negedge Clock);
        en_b = 1'b1;
        for (int i = 0; i < 12; i++) step_b_once($sformatf("w2s0_%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
